// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
//
// MEM pipeline stage that sits directly behind EX. It accepts the EX/MEM
// latched effective address and forwarded store value, runs one or two
// data-memory transactions, and returns the load result to MEM/WB. The whole
// pipeline is frozen (stall=1) while an access is in flight.
//
// Supported operations (mem_op):
//   0 NONE, 1 LDW, 2 LDB, 3 STW, 4 STB, 5 LDI, 6 STI, 7 reserved (= NONE)
//   LDI / STI are indirect: the first access reads a pointer from addr_in and
//   the second access loads from / stores to that pointer.
//
// Ports:
//   clk          pipeline clock
//   reset        synchronous, active-high reset
//   valid_in     EX/MEM register holds a live instruction
//   mem_op       operation code (see above)
//   addr_in      effective address from the ALU
//   store_data   forwarded store value
//   dmem_rdata   memory read data, valid with dmem_resp
//   dmem_resp    one-cycle completion pulse from memory (latency >= 1)
//   dmem_address memory address (word aligned)
//   dmem_read    read request, held until dmem_resp
//   dmem_write   write request, held until dmem_resp
//   dmem_wmask   byte enables, bit1 = high byte
//   dmem_wdata   write data
//   mem_data_out load result, valid while done=1 (0 for stores)
//   done         one-cycle pulse when the access completes
//   stall        freeze upstream pipeline registers and MEM/WB
//
// WIDTH is fixed at 16; the byte-lane logic assumes a two-byte word.
// ----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [2:0]       mem_op,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_resp,
    output logic [WIDTH-1:0] dmem_address,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [1:0]       dmem_wmask,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [WIDTH-1:0] mem_data_out,
    output logic             done,
    output logic             stall
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LDW  = 3'd1;
    localparam logic [2:0] OP_LDB  = 3'd2;
    localparam logic [2:0] OP_STW  = 3'd3;
    localparam logic [2:0] OP_STB  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_STI  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    // Any code other than NONE and the reserved code starts an access.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op != OP_NONE) && (op != OP_RSVD);
    endfunction

    function automatic logic is_indirect(input logic [2:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    // Memory is word addressed on the bus; the low address bit only selects
    // a byte lane.
    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:1], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] sext_byte(input logic [7:0] b);
        return {{(WIDTH-8){b[7]}}, b};
    endfunction

    // Result written to MEM/WB. For LDI the byte-select argument is unused
    // because the second access is always a full word.
    function automatic logic [WIDTH-1:0] capture_result(
        input logic [2:0]       op,
        input logic             hi_byte,
        input logic [WIDTH-1:0] rdata
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_LDW, OP_LDI: res = rdata;
            OP_LDB:         res = hi_byte ? sext_byte(rdata[WIDTH-1 -: 8])
                                          : sext_byte(rdata[7:0]);
            default:        res = '0;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State and latched operands
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [2:0]       op_q,     op_d;
    logic [WIDTH-1:0] addr_q,   addr_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [WIDTH-1:0] ptr_q,    ptr_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic accept;

    assign accept = valid_in && is_mem_op(mem_op);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACC1;
                    op_d    = mem_op;
                    addr_d  = addr_in;
                    data_d  = store_data;
                    ptr_d   = '0;
                end
            end

            S_ACC1: begin
                if (dmem_resp) begin
                    if (is_indirect(op_q)) begin
                        ptr_d   = dmem_rdata;
                        state_d = S_ACC2;
                    end else begin
                        result_d = capture_result(op_q, addr_q[0], dmem_rdata);
                        state_d  = S_DONE;
                    end
                end
            end

            S_ACC2: begin
                if (dmem_resp) begin
                    result_d = capture_result(op_q, 1'b0, dmem_rdata);
                    state_d  = S_DONE;
                end
            end

            // DONE is a single cycle; the pipeline advances at its end so the
            // instruction now on the inputs is a new one.
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NONE;
            addr_q   <= '0;
            data_q   <= '0;
            ptr_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------------
    // Memory request decode
    //
    // Driven only from state and latched operands so the bus stays constant
    // for the whole request, regardless of what EX presents meanwhile.
    // ------------------------------------------------------------------------
    always_comb begin
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_wmask   = 2'b00;
        dmem_address = '0;
        dmem_wdata   = '0;

        case (state_q)
            S_ACC1: begin
                dmem_address = word_align(addr_q);
                case (op_q)
                    OP_STW: begin
                        dmem_write = 1'b1;
                        dmem_wmask = 2'b11;
                        dmem_wdata = data_q;
                    end
                    OP_STB: begin
                        // Replicate the byte on both lanes; the mask picks
                        // the lane that is actually written.
                        dmem_write = 1'b1;
                        dmem_wmask = addr_q[0] ? 2'b10 : 2'b01;
                        dmem_wdata = {data_q[7:0], data_q[7:0]};
                    end
                    default: begin
                        // LDW, LDB, and the pointer fetch of LDI / STI
                        dmem_read = 1'b1;
                    end
                endcase
            end

            S_ACC2: begin
                dmem_address = word_align(ptr_q);
                if (op_q == OP_STI) begin
                    dmem_write = 1'b1;
                    dmem_wmask = 2'b11;
                    dmem_wdata = data_q;
                end else begin
                    dmem_read = 1'b1;
                end
            end

            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pipeline handshake
    // ------------------------------------------------------------------------
    // The accept cycle stalls too, so EX/MEM holds the instruction while the
    // access runs. Held low in reset so the pipeline is never frozen there.
    assign stall = !reset && (((state_q == S_IDLE) && accept) ||
                              (state_q == S_ACC1) ||
                              (state_q == S_ACC2));

    assign done         = (state_q == S_DONE);
    assign mem_data_out = result_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] LDW  = 3'd1;
    localparam logic [2:0] LDB  = 3'd2;
    localparam logic [2:0] STW  = 3'd3;
    localparam logic [2:0] STB  = 3'd4;
    localparam logic [2:0] LDI  = 3'd5;
    localparam logic [2:0] STI  = 3'd6;
    localparam logic [2:0] RSVD = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [2:0]  mem_op = 3'd0;
    logic [15:0] addr_in = 16'h0;
    logic [15:0] store_data = 16'h0;
    logic [15:0] dmem_rdata = 16'h0;
    logic        dmem_resp = 1'b0;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_wmask;
    logic [15:0] dmem_wdata;
    logic [15:0] mem_data_out;
    logic        done;
    logic        stall;

    mem_access_stage #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .mem_op       (mem_op),
        .addr_in      (addr_in),
        .store_data   (store_data),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .mem_data_out (mem_data_out),
        .done         (done),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Counters and comparison helper
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model and responder
    // ------------------------------------------------------------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
    } acc_t;

    logic [15:0] mem [logic [15:0]];
    acc_t        acc_log[$];
    int          lat_q[$];
    logic [15:0] exp_q[$];
    bit          spur_req = 1'b0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    function automatic void mem_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
        logic [15:0] cur;
        cur = mem_rd(a);
        if (m[0]) cur[7:0]  = d[7:0];
        if (m[1]) cur[15:8] = d[15:8];
        mem[a] = cur;
    endfunction

    int          cnt = 0;
    int          cur_lat = 1;
    logic [15:0] f_addr, f_wdata;
    logic [1:0]  f_mask;
    logic        f_rd;

    always @(posedge clk) begin
        #1;
        dmem_resp = 1'b0;
        if (reset) begin
            cnt = 0;
        end else if (dmem_read || dmem_write) begin
            if (cnt == 0) begin
                if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
                else cur_lat = 1;
                f_addr  = dmem_address;
                f_wdata = dmem_wdata;
                f_mask  = dmem_wmask;
                f_rd    = dmem_read;
            end else begin
                chk("req_addr_stable", dmem_address, f_addr);
                chk("req_wdata_stable", dmem_wdata, f_wdata);
                chk("req_mask_stable", 16'(dmem_wmask), 16'(f_mask));
                chk("req_kind_stable", 16'(dmem_read), 16'(f_rd));
            end
            cnt++;
            if (cnt >= cur_lat) begin
                dmem_resp = 1'b1;
                if (dmem_read) dmem_rdata = mem_rd(dmem_address);
                else mem_wr(dmem_address, dmem_wdata, dmem_wmask);
                acc_log.push_back('{dmem_write, dmem_address, dmem_wdata, dmem_wmask});
                cnt = 0;
            end
        end else begin
            cnt = 0;
            if (spur_req) begin
                dmem_resp  = 1'b1;
                dmem_rdata = 16'hDEAD;
                spur_req   = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_wr_exclusive", 16'(dmem_read & dmem_write), 16'h0);
            if (done) begin
                done_cnt++;
                chk("done_no_request", 16'({dmem_read, dmem_write}), 16'h0);
                chk("done_no_stall", 16'(stall), 16'h0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding, data 0x%0h, expected no done", mem_data_out);
                end else begin
                    chk("load_result", mem_data_out, exp_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue one instruction and follow it to retirement
    // ------------------------------------------------------------------
    task automatic run_instr(input logic vld, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] d, input logic exp_done,
                             input logic [15:0] exp_res, input int exp_stall, input string tag);
        int stalls;
        bit seen;
        valid_in   = vld;
        mem_op     = op;
        addr_in    = a;
        store_data = d;
        stalls = 0;
        seen   = 1'b0;
        if (exp_done) begin
            exp_q.push_back(exp_res);
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                if (stall) stalls++;
                if (done) seen = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!seen) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_timeout: no done within 100 cycles, expected done", tag);
            end
            chk({tag, "_stall_cycles"}, 16'(stalls), 16'(exp_stall));
        end else begin
            @(negedge clk);
            chk({tag, "_stall"}, 16'(stall), 16'(exp_stall));
            chk({tag, "_no_done"}, 16'(done), 16'h0);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        mem_op   = NONE;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        int          lat1;
        int          lat2;
        logic [15:0] ia;
        logic [15:0] iv;
        logic [15:0] ia2;
        logic [15:0] iv2;
        logic        exp_done;
        logic [15:0] exp_res;
        int          exp_stall;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        int          d0;

        vecs[0]  = '{1'b1, LDW,  16'h3001, 16'h0000, 3, 0, 16'h3000, 16'hBEEF, 16'h3000, 16'hBEEF, 1'b1, 16'hBEEF, 4};
        vecs[1]  = '{1'b1, LDB,  16'h2001, 16'h0000, 1, 0, 16'h2000, 16'h80FF, 16'h2000, 16'h80FF, 1'b1, 16'hFF80, 2};
        vecs[2]  = '{1'b1, LDB,  16'h2000, 16'h0000, 2, 0, 16'h2000, 16'h807F, 16'h2000, 16'h807F, 1'b1, 16'h007F, 3};
        vecs[3]  = '{1'b1, STW,  16'h0400, 16'h5A5A, 2, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b1, 16'h0000, 3};
        vecs[4]  = '{1'b1, LDW,  16'h0401, 16'h0000, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b1, 16'h5A5A, 2};
        vecs[5]  = '{1'b1, LDB,  16'h0401, 16'h0000, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b1, 16'h005A, 2};
        vecs[6]  = '{1'b1, STB,  16'h0400, 16'h00C3, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b1, 16'h0000, 2};
        vecs[7]  = '{1'b1, LDB,  16'h0400, 16'h0000, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b1, 16'hFFC3, 2};
        vecs[8]  = '{1'b1, LDI,  16'h0200, 16'h0000, 2, 1, 16'h0200, 16'h0301, 16'h0300, 16'hC0DE, 1'b1, 16'hC0DE, 4};
        vecs[9]  = '{1'b1, STI,  16'h0210, 16'h7777, 1, 3, 16'h0210, 16'h0500, 16'hFFF0, 16'h0000, 1'b1, 16'h0000, 5};
        vecs[10] = '{1'b1, LDW,  16'h0500, 16'h0000, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b1, 16'h7777, 2};
        vecs[11] = '{1'b1, NONE, 16'h0400, 16'h1111, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b0, 16'h0000, 0};
        vecs[12] = '{1'b1, RSVD, 16'h0400, 16'h2222, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b0, 16'h0000, 0};
        vecs[13] = '{1'b0, LDW,  16'h0400, 16'h3333, 1, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1'b0, 16'h0000, 0};

        // Reset held with a live LDW on the inputs
        reset = 1'b1; valid_in = 1'b1; mem_op = LDW; addr_in = 16'h3001; store_data = 16'h0;
        mem[16'h3000] = 16'hBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_read", 16'(dmem_read), 16'h0);
        chk("rst_write", 16'(dmem_write), 16'h0);
        chk("rst_wmask", 16'(dmem_wmask), 16'h0);
        chk("rst_address", dmem_address, 16'h0);
        chk("rst_wdata", dmem_wdata, 16'h0);
        chk("rst_data_out", mem_data_out, 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        lat_q.push_back(1);
        acc_log.delete();
        run_instr(1'b1, LDW, 16'h3001, 16'h0, 1'b1, 16'hBEEF, 2, "post_reset_ldw");
        chk("post_reset_acc_count", 16'(acc_log.size()), 16'd1);
        if (acc_log.size() > 0) chk("post_reset_addr", acc_log[0].addr, 16'h3000);

        // Table-driven single instructions
        for (int i = 0; i < NV; i++) begin
            mem[vecs[i].ia]  = vecs[i].iv;
            mem[vecs[i].ia2] = vecs[i].iv2;
            if (vecs[i].exp_done) begin
                lat_q.push_back(vecs[i].lat1);
                if (vecs[i].op == LDI || vecs[i].op == STI) lat_q.push_back(vecs[i].lat2);
            end
            acc_log.delete();
            run_instr(vecs[i].vld, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_done,
                      vecs[i].exp_res, vecs[i].exp_stall, $sformatf("vec%0d", i));
            if (vecs[i].exp_done) begin
                chk($sformatf("vec%0d_has_access", i), 16'(acc_log.size() > 0), 16'h1);
                if (acc_log.size() > 0) begin
                    chk($sformatf("vec%0d_first_addr", i), acc_log[0].addr, {vecs[i].addr[15:1], 1'b0});
                    chk($sformatf("vec%0d_first_is_write", i), 16'(acc_log[0].wr),
                        16'(vecs[i].op == STW || vecs[i].op == STB));
                end
            end
        end

        // STB to an odd address: high lane only, byte replicated
        mem[16'h1002] = 16'h0000;
        lat_q.push_back(1);
        acc_log.delete();
        run_instr(1'b1, STB, 16'h1003, 16'h12AB, 1'b1, 16'h0000, 2, "stb_odd");
        chk("stb_acc_count", 16'(acc_log.size()), 16'd1);
        if (acc_log.size() > 0) begin
            chk("stb_is_write", 16'(acc_log[0].wr), 16'h1);
            chk("stb_addr", acc_log[0].addr, 16'h1002);
            chk("stb_mask", 16'(acc_log[0].mask), 16'h2);
            chk("stb_wdata", acc_log[0].wdata, 16'hABAB);
        end
        chk("stb_mem_after", mem_rd(16'h1002), 16'hAB00);

        // STI: pointer read then full-word write to the pointer
        mem[16'h0100] = 16'h4444;
        lat_q.push_back(1);
        lat_q.push_back(1);
        acc_log.delete();
        d0 = done_cnt;
        run_instr(1'b1, STI, 16'h0100, 16'h9876, 1'b1, 16'h0000, 3, "sti");
        chk("sti_acc_count", 16'(acc_log.size()), 16'd2);
        if (acc_log.size() >= 2) begin
            chk("sti_ptr_is_read", 16'(acc_log[0].wr), 16'h0);
            chk("sti_ptr_addr", acc_log[0].addr, 16'h0100);
            chk("sti_wr_is_write", 16'(acc_log[1].wr), 16'h1);
            chk("sti_wr_addr", acc_log[1].addr, 16'h4444);
            chk("sti_wr_mask", 16'(acc_log[1].mask), 16'h3);
            chk("sti_wr_wdata", acc_log[1].wdata, 16'h9876);
        end
        chk("sti_done_pulses", 16'(done_cnt - d0), 16'd1);

        // LDI aborted by reset during the second access
        mem[16'h0200] = 16'h0301;
        mem[16'h0300] = 16'hC0DE;
        lat_q.push_back(1);
        lat_q.push_back(5);
        valid_in = 1'b1; mem_op = LDI; addr_in = 16'h0200; store_data = 16'h0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk);
            #1;
            if (dmem_read && dmem_address == 16'h0300) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ldi_reach_acc2: second access to 0x300 not seen within 20 cycles, expected it");
        end
        reset = 1'b1; valid_in = 1'b0; mem_op = NONE;
        d0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        chk("ldi_rst_read", 16'(dmem_read), 16'h0);
        chk("ldi_rst_write", 16'(dmem_write), 16'h0);
        chk("ldi_rst_done", 16'(done), 16'h0);
        chk("ldi_rst_stall", 16'(stall), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ldi_rst_no_done", 16'(done_cnt - d0), 16'h0);
        lat_q.delete();
        lat_q.push_back(2);
        run_instr(1'b1, LDW, 16'h3000, 16'h0, 1'b1, 16'hBEEF, 3, "ldw_after_abort");

        // Memory response while idle must be ignored
        d0 = done_cnt;
        spur_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("spurious_resp_no_stall", 16'(stall), 16'h0);
        chk("spurious_resp_no_done", 16'(done_cnt - d0), 16'h0);
        @(posedge clk);
        #1;

        // Back-to-back STW then NONE: the NONE adds no stall
        lat_q.push_back(2);
        run_instr(1'b1, STW, 16'h0600, 16'h0001, 1'b1, 16'h0000, 3, "b2b_stw");
        run_instr(1'b1, NONE, 16'h0600, 16'h0002, 1'b0, 16'h0000, 0, "b2b_none");
        chk("b2b_stw_mem", mem_rd(16'h0600), 16'h0001);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
